// File: rtl/generation_scheduler.sv
// Generation scheduler for a cellular-automaton display: turns button edges and
// vsync rises into one-cycle generation ticks and pattern-load pulses.
module generation_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        speed_btn,
  input  logic        load_btn,
  output logic        gen_tick,
  output logic        load_pulse,
  output logic [1:0]  speed_level,
  output logic [1:0]  state,
  output logic [7:0]  frame_count,
  output logic [15:0] gen_count
);

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    LOAD   = 2'd3
  } state_t;

  state_t      cur_state, nxt_state;
  logic        vsync_q, run_q, step_q, speed_q, load_q;
  logic        vsync_rise, run_rise, step_rise, speed_rise, load_rise;
  logic [7:0]  period;
  logic        last_frame;
  logic [1:0]  speed_n;
  logic [7:0]  frame_n;
  logic [15:0] gen_n;
  logic        tick_n, load_n;

  assign vsync_rise = vsync & ~vsync_q;
  assign run_rise   = run_btn & ~run_q;
  assign step_rise  = step_btn & ~step_q;
  assign speed_rise = speed_btn & ~speed_q;
  assign load_rise  = load_btn & ~load_q;

  // gen_tick and load_pulse are single-cycle strobes with no handshake: the grid
  // must act on every cycle in which one is high; neither can be stalled.
  assign period     = 8'd200 - (8'd50 * {6'd0, speed_level});
  // >= rather than == so a speed increase mid-generation ticks on the next vsync.
  assign last_frame = ({1'b0, frame_count} + 9'd1) >= {1'b0, period};
  assign state      = cur_state;

  always_comb begin
    nxt_state = cur_state;
    speed_n   = speed_rise ? speed_level + 2'd1 : speed_level;
    frame_n   = frame_count;
    gen_n     = gen_count;
    tick_n    = 1'b0;
    load_n    = 1'b0;
    if (load_rise) begin
      nxt_state = LOAD;
      load_n    = 1'b1;
      frame_n   = 8'd0;
      gen_n     = 16'd0;
    end else begin
      case (cur_state)
        PAUSED: begin
          if (step_rise) begin
            nxt_state = STEP;
            tick_n    = 1'b1;
            gen_n     = gen_count + 16'd1;
          end else if (run_rise) begin
            nxt_state = RUN;
            frame_n   = 8'd0;
          end
        end
        RUN: begin
          if (run_rise) begin
            nxt_state = PAUSED;
          end else if (vsync_rise) begin
            if (last_frame) begin
              tick_n  = 1'b1;
              frame_n = 8'd0;
              gen_n   = gen_count + 16'd1;
            end else begin
              frame_n = frame_count + 8'd1;
            end
          end
        end
        STEP:    nxt_state = PAUSED;
        LOAD:    nxt_state = PAUSED;
        default: nxt_state = PAUSED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= PAUSED;
      speed_level <= 2'd0;
      frame_count <= 8'd0;
      gen_count   <= 16'd0;
      gen_tick    <= 1'b0;
      load_pulse  <= 1'b0;
      vsync_q     <= 1'b0;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      speed_q     <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      speed_level <= speed_n;
      frame_count <= frame_n;
      gen_count   <= gen_n;
      gen_tick    <= tick_n;
      load_pulse  <= load_n;
      vsync_q     <= vsync;
      run_q       <= run_btn;
      step_q      <= step_btn;
      speed_q     <= speed_btn;
      load_q      <= load_btn;
    end
  end

endmodule
